// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer (DIV/DIVU) for the execute stage.
// Optional macro DIV_ZERO_FAST_EN: a divide-by-zero accept goes straight to DONE.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             annulE,
    output logic             stall_divE,
    output logic             div_busy,
    output logic             div_valid,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [WIDTH:0]   ONE_X = 1;
    localparam logic [WIDTH-1:0] ONE_W = 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d, dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d, dvnd_q, dvnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

    logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag, shifted, step_rem;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] step_quo, fin_q, fin_r;
    logic             last_step, stall_c, valid_c;
    logic             unused_bits;

    // Operand magnitudes carry one extra bit so that |0x80000000| is representable.
    assign a_ext = {signedE & srcaE[WIDTH-1], srcaE};
    assign b_ext = {signedE & srcbE[WIDTH-1], srcbE};
    assign a_mag = a_ext[WIDTH] ? (~a_ext + ONE_X) : a_ext;
    assign b_mag = b_ext[WIDTH] ? (~b_ext + ONE_X) : b_ext;

    assign shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {1'b0, dvsr_q};
    assign step_rem = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Divide-by-zero overrides the sign fix: all-ones quotient, raw dividend remainder.
    always_comb begin
        fin_q = negq_q ? (~step_quo + ONE_W) : step_quo;
        fin_r = negr_q ? (~step_rem[WIDTH-1:0] + ONE_W) : step_rem[WIDTH-1:0];
        if (dz_q) begin
            fin_q = '1;
            fin_r = dvnd_q;
        end
    end

    assign unused_bits = a_mag[WIDTH] ^ rem_q[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        dvnd_d  = dvnd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall_c = 1'b0;
        valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (startE && !annulE) begin
                    stall_c = 1'b1;
                    dvnd_d  = srcaE;
                    quo_d   = a_mag[WIDTH-1:0];
                    dvsr_d  = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    negq_d  = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                    negr_d  = signedE & srcaE[WIDTH-1];
                    dz_d    = (srcbE == '0);
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (srcbE == '0) begin
                        hi_d    = srcaE;
                        lo_d    = '1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                rem_d   = step_rem;
                quo_d   = step_quo;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d    = fin_r;
                    lo_d    = fin_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Annul wins over everything and leaves the last delivered result in place.
        if (annulE) begin
            stall_c = 1'b0;
            valid_c = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            dvnd_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            dvnd_q  <= dvnd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall_divE = stall_c & resetn;
    assign div_valid  = valid_c & resetn;
    assign div_busy   = (state_q != IDLE);
    assign div_hi     = hi_q;
    assign div_lo     = lo_q;
endmodule
